wb_scoreboard: RTL
==================

Name: wb_scoreboard

Overview:
- RAW-hazard scoreboard and issue gate between IDU and EXU for the multi-stage IFU/IDU/EXU/LSU/WBU handshake pipeline.
- Tracks pending GPR writes (rd, reg_en) and CSR writes (csr_rd, csreg_en) from issue until writeback.
- Deasserts issue_ready while a decoded instruction reads a register still pending, or while the in-flight limit is reached.

Parameters:
- CNT_W, 2, width of each per-register pending counter; max pending writes per register = 2^CNT_W-1.
- MAX_INFLIGHT, 4, max instructions issued but not yet written back (1..15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- issue_valid  in  1  IDU has a decoded instruction
- issue_ready  out  1  EXU side may accept it; fire = issue_valid && issue_ready
- issue_rs1  in  5  source reg 1
- issue_rs1_use  in  1  rs1 is read
- issue_rs2  in  5  source reg 2
- issue_rs2_use  in  1  rs2 is read
- issue_rd  in  5  destination GPR
- issue_reg_en  in  1  writes GPR
- issue_csr_src  in  2  CSR index read
- issue_csr_use  in  1  CSR is read
- issue_csr_rd  in  2  CSR index written
- issue_csreg_en  in  1  writes CSR
- wb_valid  in  1  one instruction retires this cycle (single-cycle pulse per instruction)
- wb_rd  in  5  retiring rd
- wb_reg_en  in  1  retiring instruction wrote GPR
- wb_csr_rd  in  2  retiring CSR index
- wb_csreg_en  in  1  retiring instruction wrote CSR
- flush  in  1  discard all tracking (redirect/trap)
- gpr_busy_o  out  32  bit i = counter[i]!=0; bit 0 always 0
- csr_busy_o  out  4  bit j = csr counter[j]!=0
- inflight_o  out  4  instructions issued and not retired
- err_o  out  1  sticky protocol error

Behaviour:
- State: 31 GPR counters (x1..x31, CNT_W bits each), 4 CSR counters, inflight counter, err flag. x0 is never tracked; writes to x0 are ignored.
- Reset (async, immediate): all counters 0, err_o=0. Outputs: gpr_busy_o=0, csr_busy_o=0, inflight_o=0, issue_ready=1.
- Hazard (combinational, from registered counters only; no same-cycle wb bypass):
  - (rs1_use && rs1!=0 && cnt[rs1]!=0)
  - or (rs2_use && rs2!=0 && cnt[rs2]!=0)
  - or (csr_use && ccnt[csr_src]!=0)
- issue_ready = !hazard && inflight<MAX_INFLIGHT && !(reg_en && rd!=0 && cnt[rd]==max) && !(csreg_en && ccnt[csr_rd]==max).
- issue_ready does not depend on issue_valid. Once deasserted, it rises the cycle after the blocking writeback is registered, so latency from wb to release is 1 cycle.
- On fire: cnt[rd]+=1 if reg_en && rd!=0; ccnt[csr_rd]+=1 if csreg_en; inflight+=1.
- On wb_valid: cnt[wb_rd]-=1 if wb_reg_en && wb_rd!=0; ccnt[wb_csr_rd]-=1 if wb_csreg_en; inflight-=1.
- Fire and wb in the same cycle on the same counter: net 0, counter unchanged. Same for inflight.
- Underflow: wb decrement of a 0 counter, or wb_valid with inflight==0. Counter holds at 0 and err_o=1 (sticky until rst).
- flush: next edge clears all GPR/CSR counters and inflight to 0. It overrides fire and wb in that cycle; neither is counted. err_o is kept.
- rst mid-operation: everything clears immediately, with no pending fire/wb recorded.

Test Plan:
- After reset, issue rd=5 reg_en, then issue rs1=5 -> second issue_ready=0; gpr_busy_o=0x20; wb rd=5 at cycle T -> issue_ready=1 at T+1, gpr_busy_o=0.
- Issue rd=0 reg_en, then rs1=0 rs2=0 -> never stalls; gpr_busy_o stays 0; inflight_o=1 then 2.
- Fill 4 independent issues without wb -> inflight_o=4, issue_ready=0; one wb -> inflight_o=3, ready=1 next cycle.
- Same cycle: fire rd=7 and wb rd=7 while cnt[7]=1 -> cnt stays 1, gpr_busy_o[7]=1, inflight unchanged.
- Issue csreg_en csr_rd=2, then csr_use csr_src=2 -> stall; csr_busy_o=0b0100; flush asserted together with a valid issue -> all busy 0, inflight 0, issue not counted.
- wb_valid with wb_reg_en rd=9 while idle -> err_o=1 and stays 1 through flush; cleared only by rst (async, mid-cycle).

Source files
------------

// File: rtl/wb_scoreboard.sv
// RAW-hazard scoreboard gating IDU->EXU issue on pending GPR/CSR writes and the in-flight limit.
// Latency: issue_ready is combinational from registered counters; a writeback releases a stall one cycle later.
// Backpressure: issue_ready drops on a source hazard, a saturated destination counter or a full in-flight window.
module wb_scoreboard #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [4:0]  issue_rs1,
  input  logic        issue_rs1_use,
  input  logic [4:0]  issue_rs2,
  input  logic        issue_rs2_use,
  input  logic [4:0]  issue_rd,
  input  logic        issue_reg_en,
  input  logic [1:0]  issue_csr_src,
  input  logic        issue_csr_use,
  input  logic [1:0]  issue_csr_rd,
  input  logic        issue_csreg_en,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_en,
  input  logic [1:0]  wb_csr_rd,
  input  logic        wb_csreg_en,
  input  logic        flush,
  output logic [31:0] gpr_busy_o,
  output logic [3:0]  csr_busy_o,
  output logic [3:0]  inflight_o,
  output logic        err_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] gpr_cnt [32];
  logic [CNT_W-1:0] csr_cnt [4];
  logic [3:0]       inflight;
  logic             err;

  logic        hazard;
  logic        rd_full;
  logic        csr_full;
  logic        fire;
  logic        underflow;
  logic [31:0] gpr_inc;
  logic [31:0] gpr_dec;
  logic [3:0]  csr_inc;
  logic [3:0]  csr_dec;

  // Only registered counters are consulted: a writeback in this cycle does not bypass.
  assign hazard = (issue_rs1_use && (issue_rs1 != 5'd0) && (gpr_cnt[issue_rs1] != '0)) ||
                  (issue_rs2_use && (issue_rs2 != 5'd0) && (gpr_cnt[issue_rs2] != '0)) ||
                  (issue_csr_use && (csr_cnt[issue_csr_src] != '0));

  assign rd_full  = issue_reg_en && (issue_rd != 5'd0) && (gpr_cnt[issue_rd] == CNT_MAX);
  assign csr_full = issue_csreg_en && (csr_cnt[issue_csr_rd] == CNT_MAX);

  assign issue_ready = !hazard && (inflight < 4'(MAX_INFLIGHT)) && !rd_full && !csr_full;
  assign fire        = issue_valid && issue_ready;

  assign gpr_inc = (fire && issue_reg_en && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
  assign gpr_dec = (wb_valid && wb_reg_en && (wb_rd != 5'd0)) ? (32'd1 << wb_rd) : 32'd0;
  assign csr_inc = (fire && issue_csreg_en) ? (4'd1 << issue_csr_rd) : 4'd0;
  assign csr_dec = (wb_valid && wb_csreg_en) ? (4'd1 << wb_csr_rd) : 4'd0;

  assign underflow = wb_valid &&
                     ((inflight == 4'd0) ||
                      (wb_reg_en && (wb_rd != 5'd0) && (gpr_cnt[wb_rd] == '0)) ||
                      (wb_csreg_en && (csr_cnt[wb_csr_rd] == '0)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) gpr_cnt[i] <= '0;
      for (int j = 0; j < 4; j++) csr_cnt[j] <= '0;
      inflight <= 4'd0;
      err      <= 1'b0;
    end else if (flush) begin
      // Flush discards this cycle's fire/wb entirely, including any underflow they would flag.
      for (int i = 0; i < 32; i++) gpr_cnt[i] <= '0;
      for (int j = 0; j < 4; j++) csr_cnt[j] <= '0;
      inflight <= 4'd0;
    end else begin
      if (underflow) err <= 1'b1;
      for (int i = 1; i < 32; i++) begin
        if (gpr_inc[i] && !gpr_dec[i])
          gpr_cnt[i] <= gpr_cnt[i] + CNT_W'(1);
        else if (!gpr_inc[i] && gpr_dec[i] && (gpr_cnt[i] != '0))
          gpr_cnt[i] <= gpr_cnt[i] - CNT_W'(1);
      end
      for (int j = 0; j < 4; j++) begin
        if (csr_inc[j] && !csr_dec[j])
          csr_cnt[j] <= csr_cnt[j] + CNT_W'(1);
        else if (!csr_inc[j] && csr_dec[j] && (csr_cnt[j] != '0))
          csr_cnt[j] <= csr_cnt[j] - CNT_W'(1);
      end
      if (fire && !wb_valid)
        inflight <= inflight + 4'd1;
      else if (!fire && wb_valid && (inflight != 4'd0))
        inflight <= inflight - 4'd1;
    end
  end

  always_comb begin
    gpr_busy_o = 32'd0;
    csr_busy_o = 4'd0;
    for (int i = 1; i < 32; i++) gpr_busy_o[i] = (gpr_cnt[i] != '0);
    for (int j = 0; j < 4; j++) csr_busy_o[j] = (csr_cnt[j] != '0);
  end

  assign inflight_o = inflight;
  assign err_o      = err;

endmodule
